// File: rtl/reg_scan_master.sv
// reg_scan_master: serial scan initiator for a register-file shift port.
// Takes one parallel read/write request at a time.
// Shifts a framed bit stream out on sIn, MSB first, using a divided scan clock.
// On reads it captures sOut while the data bits are shifted.
// Frame layout: op bit, address, [turnaround,] data.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for a request, reqReady high
// SHIFT_HDR  | shifting op bit and address bits
// TURN       | read only: one turnaround bit with sIn low
// SHIFT_DATA | shifting W data bits (write data out, or read data in)
// DONE       | one-cycle response pulse, scan outputs parked low
module reg_scan_master #(
    parameter int SIZE    = 16,
    parameter int WIDTH   = 32,
    parameter int CLK_DIV = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  reqValid,
    output logic                                  reqReady,
    input  logic                                  reqWrite,
    input  logic [((SIZE > 1) ? $clog2(SIZE) : 1)-1:0] reqAddr,
    input  logic [WIDTH-1:0]                      reqData,
    output logic                                  respValid,
    output logic [WIDTH-1:0]                      respData,
    output logic                                  busy,
    output logic                                  sClock,
    output logic                                  sEnable,
    output logic                                  sIn,
    input  logic                                  sOut
);

    localparam int AW    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH + AW + 1);
    localparam int TX_W  = AW + WIDTH;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] HDR_LOAD  = BIT_W'(AW);
    localparam logic [BIT_W-1:0] DATA_LOAD = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SHIFT_HDR  = 3'd1,
        TURN       = 3'd2,
        SHIFT_DATA = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  half_q, half_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [TX_W-1:0]   tx_q, tx_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic              wr_q, wr_d;
    logic              sclk_q, sclk_d;
    logic              sen_q, sen_d;
    logic              sin_q, sin_d;

    // State and datapath registers; reset parks every scan output low at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            half_q  <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            sclk_q  <= 1'b0;
            sen_q   <= 1'b0;
            sin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            sclk_q  <= sclk_d;
            sen_q   <= sen_d;
            sin_q   <= sin_d;
        end
    end

    // Next-state: half-period down-counter paces sClock; bit counter marks phase ends.
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        sclk_d  = sclk_q;
        sen_d   = sen_q;
        sin_d   = sin_q;
        unique case (state_q)
            IDLE: begin
                if (reqValid) begin
                    state_d = SHIFT_HDR;
                    wr_d    = reqWrite;
                    // Read frames carry zeros after the address, which also
                    // supplies the low turnaround and data-phase sIn bits.
                    tx_d    = {reqAddr, (reqWrite ? reqData : {WIDTH{1'b0}})};
                    rdata_d = '0;
                    half_d  = HALF_LOAD;
                    bit_d   = HDR_LOAD;
                    sclk_d  = 1'b0;
                    sen_d   = 1'b1;
                    sin_d   = reqWrite;
                end
            end
            SHIFT_HDR, TURN, SHIFT_DATA: begin
                if (half_q != '0) begin
                    half_d = half_q - CNT_W'(1);
                end else if (!sclk_q) begin
                    // Rising half: target latches sIn, we latch sOut.
                    half_d = HALF_LOAD;
                    sclk_d = 1'b1;
                    if (state_q == SHIFT_DATA && !wr_q) begin
                        rdata_d = {rdata_q[WIDTH-2:0], sOut};
                    end
                end else begin
                    // Falling half ends the bit period; next bit goes out here.
                    half_d = HALF_LOAD;
                    sclk_d = 1'b0;
                    sin_d  = tx_q[TX_W-1];
                    tx_d   = tx_q << 1;
                    if (bit_q != '0) begin
                        bit_d = bit_q - BIT_W'(1);
                    end else begin
                        unique case (state_q)
                            SHIFT_HDR: begin
                                if (wr_q) begin
                                    state_d = SHIFT_DATA;
                                    bit_d   = DATA_LOAD;
                                end else begin
                                    state_d = TURN;
                                    bit_d   = '0;
                                end
                            end
                            TURN: begin
                                state_d = SHIFT_DATA;
                                bit_d   = DATA_LOAD;
                            end
                            default: begin
                                state_d = DONE;
                                sen_d   = 1'b0;
                                sin_d   = 1'b0;
                            end
                        endcase
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                sen_d   = 1'b0;
                sclk_d  = 1'b0;
                sin_d   = 1'b0;
            end
        endcase
    end

    // Outputs: handshake and status decode from state, scan pins straight from flops.
    always_comb begin
        reqReady  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        respValid = (state_q == DONE);
        respData  = rdata_q;
        sClock    = sclk_q;
        sEnable   = sen_q;
        sIn       = sin_q;
    end

endmodule

// File: doc/reg_scan_master.md
Name: reg_scan_master

Overview:
- Serial scan initiator for the register-file JTAG shift port: it drives sClock/sEnable/sIn and samples sOut on the target side.
- A debug/JTAG host issues single-register read or write requests over a parallel valid/ready interface.
- The block serialises each request into a framed bit stream and returns read data in parallel.
- It sits between the debug TAP logic and one register file's scan port.

Parameters:
- SIZE, 16, number of registers in the target file; address width A = $clog2(SIZE).
- WIDTH, WORD_LENGTH (32), register data width W.
- CLK_DIV, 2, clk cycles per sClock half period H; legal values are ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  block can accept a request; high only in IDLE.
- reqWrite  in  1  1 = write, 0 = read.
- reqAddr  in  A  target register address.
- reqData  in  W  write data.
- respValid  out  1  one-cycle pulse at transaction end.
- respData  out  W  read result; ZERO after a write.
- busy  out  1  high in every state except IDLE.
- sClock  out  1  scan clock to target.
- sEnable  out  1  frame enable to target.
- sIn  out  1  serial data to target.
- sOut  in  1  serial data from target.

Behaviour:
- Reset (rst low, async): IDLE; reqReady=1; busy=0, respValid=0, respData=0; sClock=0, sEnable=0, sIn=0; counters cleared.
- Reset mid-frame aborts the frame immediately. sEnable drops asynchronously, no respValid is produced, and the target discards any partial frame.
- Accept: reqValid&&reqReady at posedge T latches reqWrite, reqAddr and reqData. Inputs are don't-care after T.
- States:
  - IDLE -> SHIFT_HDR on accept.
  - SHIFT_HDR -> TURN (read) or SHIFT_DATA (write) after the header.
  - TURN -> SHIFT_DATA.
  - SHIFT_DATA -> DONE after W bits.
  - DONE -> IDLE after 1 cycle.
- Frame, MSB first:
  - Header: op bit (1 = write), then A address bits.
  - Write: W data bits follow the header. N = 1+A+W bit periods.
  - Read: 1 turnaround bit (sIn=0), then W data bits with sIn=0. N = 1+A+1+W bit periods.
- Bit period is 2H clk cycles:
  - sClock is low for H cycles, then high for H cycles.
  - sIn changes only in the cycle sClock goes low, or at frame start, so sIn is stable across every rising sClock.
  - The first bit is driven at T+1 with sClock=0 and sEnable=1.
- Read sampling: sOut is captured on the clk edge that raises sClock, during SHIFT_DATA only. Data is shifted into respData LSB-ward, MSB first. sOut is ignored in the header and TURN.
- DONE occurs at cycle T+1+N·2H:
  - sEnable=0, sClock=0, sIn=0.
  - respValid=1 for exactly one cycle; respData is valid in that cycle and held until the next accept.
  - reqReady=0 in DONE and returns to 1 the following cycle.
  - Back-to-back frames are separated by at least 2 cycles with sEnable low.
- Latency examples:
  - CLK_DIV=1, SIZE=16, WIDTH=32: write respValid at T+75, read at T+77.
  - CLK_DIV=2: write at T+149, read at T+153.
- Address 0 is shifted like any other; the target ignores the write and returns zero. The master does not special-case it.
- reqValid asserted while busy is ignored; there is no queueing, and the host must hold the request until reqReady.
- sClock never glitches. It is a registered output and toggles only at half-period boundaries while sEnable=1.

Test Plan:
- Reset with CLK_DIV=1: outputs hold reset values. Write addr=3, data=0xA5A5_0F0F -> sIn sequence 1,0011, then the data bits MSB first. Exactly 37 rising sClock edges; respValid at T+75; respData=0.
- Read addr=5 with a target model returning 0xDEAD_BEEF on sOut -> header 0,0101; one turnaround bit; respData=0xDEAD_BEEF at T+77; exactly 38 sClock rises.
- CLK_DIV=3, read addr=15 -> sClock high and low phases each 3 cycles; respValid at T+1+38·6 = T+229; sIn is stable on every sClock rise.
- Hold reqValid high for two back-to-back writes -> second accept 1 cycle after respValid; sEnable low for at least 2 cycles between frames; no request is lost or duplicated.
- Assert rst at bit 10 of a read -> sEnable, sClock and sIn go 0 asynchronously; no respValid. A subsequent read completes normally with correct data.
- Pulse reqValid while busy with a different address -> ignored; the in-flight frame's bits are unchanged and only one respValid is produced.
